// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared fetch definitions (FSM states, PC step, branch codes)
package pc_fetch_ctrl_pkg;
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [2:0] {
        BR_NONE,
        BR_EQ,
        BR_NE,
        BR_LT,
        BR_GE,
        BR_JAL,
        BR_JALR
    } br_code_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/pc_fetch_ctrl_pc_reg.sv
// pc_reg: program counter register with load enable and reset to the boot address
module pc_reg #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);
    // load a new pc only when the controller commits one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_o <= RESET_ADDR;
        else if (load_i) q_o <= d_i;
    end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: single-slot instruction fetch controller with redirect handling
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcload,
    input  logic [31:0] pcaddr,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc
);
    fetch_state_e state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        pend_q, pend_d;
    logic [31:0] raddr_q, raddr_d;
    logic        pc_ld;
    logic [31:0] pc_d;

    pc_reg #(.RESET_ADDR(RESET_ADDR)) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(pc_ld),
        .d_i   (pc_d),
        .q_o   (pc)
    );

    // state, slot and deferred-redirect registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            pend_q  <= 1'b0;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            pend_q  <= pend_d;
            raddr_q <= raddr_d;
        end
    end

    // next state: a redirect seen during a read poisons that read's data
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        pend_d  = pend_q;
        raddr_d = raddr_q;
        pc_ld   = 1'b0;
        pc_d    = pc;
        if (state_q == FETCH) begin
            if (imem_ack) begin
                pc_ld  = 1'b1;
                pend_d = 1'b0;
                if (pcload) pc_d = word_align(pcaddr);
                else if (pend_q) pc_d = raddr_q;
                else begin
                    pc_d    = pc + PC_INC;
                    instr_d = imem_rdata;
                    ipc_d   = pc;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end else if (pcload) begin
                pend_d  = 1'b1;
                raddr_d = word_align(pcaddr);
            end
        end else if (pcload) begin
            pc_ld   = 1'b1;
            pc_d    = word_align(pcaddr);
            valid_d = 1'b0;
            state_d = FETCH;
        end else if (valid_q && !stall) begin
            valid_d = 1'b0;
            state_d = FETCH;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
endmodule
